// File: rtl/breath_pkg.sv
// rtl/breath_pkg.sv - shared state encoding and default timing constants for breath_gen
package breath_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam int STEP_DIV_25MHZ_20MS = 500000;
  localparam int HOLD_STEPS_DEF      = 32;

endpackage

// File: rtl/breath_tick_prescaler.sv
// rtl/breath_tick_prescaler.sv - step tick strobe every DIV clocks while run is high
module tick_prescaler #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  // Dropping run clears the phase so a restart always waits a full DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/breath_gen.sv
// rtl/breath_gen.sv - triangle breathing duty-cycle source: ramp up, hold, ramp down, hold
module breath_gen
  import breath_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STEP_DIV   = STEP_DIV_25MHZ_20MS,
  parameter int HOLD_STEPS = HOLD_STEPS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] min_level,
  input  logic [WIDTH-1:0] max_level,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             rising,
  output logic             cycle_done
);

  localparam int               HW        = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_STEPS - 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             run;
  logic             tick;
  logic             hold_done;
  logic [WIDTH-1:0] lo_new;
  logic [WIDTH-1:0] duty_up;
  logic [WIDTH-1:0] duty_dn;

  assign run       = enable && (state != IDLE);
  assign hold_done = (hold_cnt == HOLD_LAST);
  // Inverted or equal levels collapse to max_level so only the holds alternate.
  assign lo_new    = (min_level < max_level) ? min_level : max_level;
  assign duty_up   = duty_cycle + ONE;
  assign duty_dn   = duty_cycle - ONE;

  tick_prescaler #(.DIV(STEP_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty_cycle <= '0;
      rising     <= 1'b0;
      cycle_done <= 1'b0;
      hold_cnt   <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      cycle_done <= 1'b0;
      if (!enable) begin
        state      <= IDLE;
        duty_cycle <= '0;
        rising     <= 1'b0;
        hold_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            lo_q       <= lo_new;
            hi_q       <= max_level;
            duty_cycle <= lo_new;
            rising     <= 1'b1;
            state      <= RISE;
          end
          // Ramps only step while strictly inside [lo_q, hi_q], so no wrap can occur.
          RISE: if (tick) begin
            if (duty_cycle == hi_q) begin
              state <= HOLD_HI;
            end else begin
              duty_cycle <= duty_up;
              if (duty_up == hi_q) state <= HOLD_HI;
            end
          end
          HOLD_HI: if (tick) begin
            if (hold_done) begin
              hold_cnt <= '0;
              rising   <= 1'b0;
              state    <= FALL;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          FALL: if (tick) begin
            if (duty_cycle == lo_q) begin
              state <= HOLD_LO;
            end else begin
              duty_cycle <= duty_dn;
              if (duty_dn == lo_q) state <= HOLD_LO;
            end
          end
          HOLD_LO: if (tick) begin
            if (hold_done) begin
              hold_cnt   <= '0;
              lo_q       <= lo_new;
              hi_q       <= max_level;
              duty_cycle <= lo_new;
              rising     <= 1'b1;
              cycle_done <= 1'b1;
              state      <= RISE;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
